seq_multiplier: RTL
===================

Name: seq_multiplier

Overview:
Parametrised sequential shift-add multiplier. It is the successor to the team's fixed 4x4 combinational product.
- Operand width is generic.
- Supports an unsigned or two's-complement signed mode, selected per operation.
- Uses a start/busy/done handshake so wide operands can be multiplied without a wide combinational array.
- Sits behind the tile's dedicated I/O wrapper, which maps operands from ui_in/uio_in and the product to uo_out/uio_out.

Parameters:
WIDTH, 4, operand width in bits (legal range 2..16); product is 2*WIDTH bits.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
ena  input  1  clock enable; when low, all state and outputs hold
start  input  1  request a multiply; sampled only when idle
signed_mode  input  1  1 = operands are two's-complement signed, 0 = unsigned; sampled with start
a  input  WIDTH  multiplicand, sampled with start
b  input  WIDTH  multiplier, sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when product is updated
product  output  2*WIDTH  result, held until the next completion

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, product=0, internal accumulator/counter=0.
- Reset mid-operation aborts the operation; no done pulse is issued.
- ena low freezes the FSM, counter, accumulator, product, busy and done. A done pulse is extended until ena returns high for one edge.
- FSM states:
  - IDLE -> CALC on an ena-qualified edge with start=1. On that edge:
    - latch |a| and |b| (magnitudes if signed_mode=1, raw values otherwise);
    - latch neg = signed_mode & (a[MSB]^b[MSB]);
    - clear the 2*WIDTH-bit accumulator;
    - load counter=WIDTH;
    - busy goes high.
  - CALC: each edge, if multiplier LSB=1, add the shifted multiplicand to the accumulator. Shift the multiplier right and the multiplicand left, then decrement the counter. Exit to FIN after exactly WIDTH edges.
  - FIN: one edge. Write product = neg ? (~acc+1) : acc, truncated to 2*WIDTH bits. Set done=1 and busy=0, then go to IDLE.
- Latency: start sampled at edge E0. Product and done are valid after edge E0+WIDTH+1. done is high for exactly one cycle.
- Back-to-back: start may be asserted in the cycle where done is high (state is IDLE). The new operation begins on that edge and product is not overwritten until its own FIN.
- start while busy=1 is ignored. It is not queued, and operands and mode are not re-sampled.
- Operands are captured only at start. Changes to a, b or signed_mode during CALC have no effect.
- Signed boundary: the magnitude of the most negative value (-2^(WIDTH-1)) is 2^(WIDTH-1), held in WIDTH+1-bit internal registers. (-2^(W-1))*(-2^(W-1)) = +2^(2W-2) is exact.
- Zero operand: still takes the full WIDTH+1 cycles, and product=0.
- Zero never produces -0: negating 0 yields 0.
- Unsigned max: (2^W-1)^2 fits in 2*WIDTH bits, so there is no overflow. No overflow flag is needed in either mode.
- busy and done are never high in the same cycle.

Test Plan:
1. Reset mid-calc. WIDTH=4, unsigned, a=15, b=15, start=1 at E0 → busy=1 at E1..E4. Then assert rst_n=0 at E2 → busy/done/product=0 immediately, FSM returns to IDLE, no done pulse.
2. Unsigned max. WIDTH=4, unsigned, a=15, b=15, start=1 at E0 → busy=1 at E1..E4, done=1 only after E5, product=0xE1 (225), busy=0 at E5.
3. Signed mixed sign. signed_mode=1, a=4'b1000 (-8), b=4'b0111 (7) → product=0xC8 (-56). Then a=-8, b=-8 → product=0x40 (64). Then a=-1, b=0 → product=0x00.
4. Busy/back-to-back:
   - during CALC, pulse start with a=3, b=3 → ignored, product=a*b of the first operation;
   - then assert start with a=2, b=5 in the done cycle → second done exactly 5 cycles later, product=0x0A;
   - product holds the first result in between.
5. ena gating. Start a=9, b=6 unsigned, drop ena for 3 cycles mid-CALC → done arrives exactly 3 cycles later than nominal, product=0x36 (54), all outputs stable while ena=0.
6. WIDTH=8 build. Signed a=0x80 (-128), b=0x80 → product=0x4000 after 9 cycles. Unsigned a=0xFF, b=0xFF → 0xFE01. Random 1000-vector run against a reference a*b in both modes with zero mismatches.

Source files
------------

// File: rtl/seq_multiplier.sv
// seq_multiplier
// Sequential shift-add multiplier with a start/busy/done handshake.
// Operands are WIDTH bits and the product is 2*WIDTH bits. Each operation
// selects unsigned or two's-complement signed mode.
// The multiplier works on operand magnitudes and applies the sign once at
// the end, so the same datapath serves both modes.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   ena          clock enable; when low, all state and outputs hold
//   start        request a multiply; sampled only while idle
//   signed_mode  1 = signed operands, 0 = unsigned; sampled with start
//   a, b         multiplicand / multiplier, sampled with start
//   busy         high while an operation is in progress
//   done         one-cycle pulse when product updates (stretched while ena low)
//   product      result, held until the next completion
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH:0]     mplier;
  logic [CW-1:0]      cnt;
  logic               neg;

  // Operands are widened by one bit so that the magnitude of the most
  // negative value, 2^(WIDTH-1), is still representable.
  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;
  logic [WIDTH:0] a_mag;
  logic [WIDTH:0] b_mag;

  assign a_ext = signed_mode ? {a[WIDTH-1], a} : {1'b0, a};
  assign b_ext = signed_mode ? {b[WIDTH-1], b} : {1'b0, b};
  assign a_mag = (signed_mode && a[WIDTH-1]) ? -a_ext : a_ext;
  assign b_mag = (signed_mode && b[WIDTH-1]) ? -b_ext : b_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          // A pending done pulse is cleared here. A start in the same
          // cycle begins the next operation immediately.
          done <= 1'b0;
          if (start) begin
            mcand  <= {{(WIDTH-1){1'b0}}, a_mag};
            mplier <= b_mag;
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= CW'(WIDTH);
            busy   <= 1'b1;
            state  <= CALC;
          end
        end

        CALC: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mplier <= mplier >> 1;
          mcand  <= mcand << 1;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= FIN;
          end
        end

        FIN: begin
          // Negating a zero accumulator yields zero, so no -0 is produced.
          product <= neg ? -acc : acc;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
